// File: rtl/fifo_write_arbiter_if.sv
// Push-side bundle between NUM_REQ valid/ready producers, the write arbiter and the FIFO.
//   req_valid  producer i has a beat
//   req_data   producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  beat of producer i accepted this cycle (one-hot or 0)
//   push       FIFO push strobe
//   wr_data    FIFO write data (granted producer's slice)
//   fifo_full  FIFO full flag (back-pressure)
//   grant_id   index of granted producer, valid when push=1
//   locked     burst lock held by the arbiter
// Modports: master = arbiter side, slave = producers + FIFO side.
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          push;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          fifo_full;
  logic [IdxW-1:0]               grant_id;
  logic                          locked;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, push, wr_data, grant_id, locked
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, push, wr_data, grant_id, locked
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the push side of a synchronous FIFO among NUM_REQ producers.
// A winner may stream up to BURST_MAX consecutive beats (burst lock) before rotation.
// All outputs are combinational from state + inputs: a beat is pushed in the cycle it is
// accepted. Every producer is back-pressured while fifo_full is high.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces all outputs to 0 while asserted
//   bus    fifo_write_arbiter_if.master (producer handshakes, FIFO push side, status)
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_MAX  = 4
) (
  input logic                  clk,
  input logic                  reset,
  fifo_write_arbiter_if.master bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(BURST_MAX + 1);

  typedef enum logic {StArb, StLock} state_e;

  state_e          r_state,    w_state_next;
  logic [IdxW-1:0] r_rr_ptr,   w_rr_ptr_next;
  logic [IdxW-1:0] r_owner,    w_owner_next;
  logic [CntW-1:0] r_beat_cnt, w_beat_cnt_next;

  logic [IdxW-1:0] w_scan_start;
  logic [IdxW-1:0] w_winner;
  logic            w_found;
  logic            w_grant;
  logic [IdxW-1:0] w_grant_id;
  logic [CntW-1:0] w_cnt_inc;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    if (idx == IdxW'(NUM_REQ - 1)) return '0;
    return idx + IdxW'(1);
  endfunction

  // Round-robin scan. In LOCK the scan only matters when the owner has dropped valid,
  // in which case the lock is released and the search starts just past the owner.
  always_comb begin
    int unsigned w_scan_idx;
    w_scan_idx   = 0;
    w_scan_start = (r_state == StLock) ? wrap_inc(r_owner) : r_rr_ptr;
    w_found      = 1'b0;
    w_winner     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = 32'(w_scan_start) + k;
      if (w_scan_idx >= NUM_REQ) w_scan_idx = w_scan_idx - NUM_REQ;
      if (!w_found && bus.req_valid[IdxW'(w_scan_idx)]) begin
        w_found  = 1'b1;
        w_winner = IdxW'(w_scan_idx);
      end
    end
  end

  // Next-state: everything holds while the FIFO is full.
  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_owner_next    = r_owner;
    w_beat_cnt_next = r_beat_cnt;
    w_grant         = 1'b0;
    w_grant_id      = '0;
    w_cnt_inc       = r_beat_cnt + CntW'(1);

    if (!bus.fifo_full) begin
      if ((r_state == StLock) && bus.req_valid[r_owner]) begin
        w_grant         = 1'b1;
        w_grant_id      = r_owner;
        w_beat_cnt_next = w_cnt_inc;
        if (w_cnt_inc == CntW'(BURST_MAX)) begin
          w_rr_ptr_next = wrap_inc(r_owner);
          w_state_next  = StArb;
        end
      end else if (w_found) begin
        w_grant    = 1'b1;
        w_grant_id = w_winner;
        if (BURST_MAX == 1) begin
          w_rr_ptr_next = wrap_inc(w_winner);
          w_state_next  = StArb;
        end else begin
          w_owner_next    = w_winner;
          w_beat_cnt_next = CntW'(1);
          w_state_next    = StLock;
        end
      end else if (r_state == StLock) begin
        // Owner went idle and nobody else is waiting: drop the lock, resume after owner.
        w_rr_ptr_next   = wrap_inc(r_owner);
        w_beat_cnt_next = '0;
        w_state_next    = StArb;
      end
    end
  end

  // Outputs are gated by reset so they read 0 for the whole reset window.
  always_comb begin
    bus.push      = 1'b0;
    bus.req_ready = '0;
    bus.grant_id  = '0;
    bus.wr_data   = '0;
    bus.locked    = 1'b0;
    if (!reset) begin
      bus.locked = (r_state == StLock);
      if (w_grant) begin
        bus.push                  = 1'b1;
        bus.req_ready[w_grant_id] = 1'b1;
        bus.grant_id              = w_grant_id;
        bus.wr_data               = bus.req_data[w_grant_id * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StArb;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_owner    <= w_owner_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter. Two instances: burst-locked (BURST_MAX=4) and
// pure per-beat round-robin (BURST_MAX=1). Stimulus pushes hand-computed expected beats
// (cycle, producer, data, locked) into per-instance queues; negedge monitors pop and compare
// whenever the DUT pushes.
module tb_fifo_write_arbiter;
  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [31:0] data;
    logic        locked;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   v_main, v_rr;
  logic         full_main;
  logic [127:0] data_pk;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  beat_t        q_main[$];
  beat_t        q_rr[$];

  fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();
  fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus_rr ();

  assign bus.req_valid    = v_main;
  assign bus.req_data     = data_pk;
  assign bus.fifo_full    = full_main;
  assign bus_rr.req_valid = v_rr;
  assign bus_rr.req_data  = data_pk;
  assign bus_rr.fifo_full = 1'b0;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .BURST_MAX(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .BURST_MAX(1)) u_dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_beat(input string tag, input beat_t e, input logic [1:0] id,
                            input logic [31:0] data, input logic [3:0] rdy, input logic lk);
    logic [3:0] exp_rdy;
    exp_rdy     = 4'b0000;
    exp_rdy[e.id] = 1'b1;
    chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
    chk({tag, "_grant_id"}, 32'(id), 32'(e.id));
    chk({tag, "_wr_data"}, data, e.data);
    chk({tag, "_req_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({tag, "_locked"}, 32'(lk), 32'(e.locked));
  endtask

  // Monitors: every push must match the oldest expected beat, in order.
  always @(negedge clk) begin : mon_main
    beat_t e;
    if (bus.push) begin
      if (q_main.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_unexpected_push: got id %0d expected no push (cycle %0d)",
                 bus.grant_id, cyc);
      end else begin
        e = q_main.pop_front();
        check_beat("main", e, bus.grant_id, bus.wr_data, bus.req_ready, bus.locked);
      end
    end
    if (full_main) chk("main_push_while_full", 32'(bus.push), 32'd0);
  end

  always @(negedge clk) begin : mon_rr
    beat_t e;
    if (bus_rr.push) begin
      if (q_rr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rr_unexpected_push: got id %0d expected no push (cycle %0d)",
                 bus_rr.grant_id, cyc);
      end else begin
        e = q_rr.pop_front();
        check_beat("rr", e, bus_rr.grant_id, bus_rr.wr_data, bus_rr.req_ready, bus_rr.locked);
      end
    end
  end

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < 4; i++) data_pk[i*32 +: 32] = base + 32'(i);
  endtask

  function automatic logic [31:0] pdata(input int id);
    return data_pk[id*32 +: 32];
  endfunction

  // One cycle on the burst instance; inputs change #1 after the rising edge.
  task automatic cyc_main(input logic [3:0] v, input logic full, input logic exp_push,
                          input int id, input logic lk);
    beat_t e;
    v_main    = v;
    full_main = full;
    if (exp_push) begin
      e = '{cyc, 2'(id), pdata(id), lk};
      q_main.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_rr(input logic [3:0] v, input int id);
    beat_t e;
    v_rr = v;
    e    = '{cyc, 2'(id), pdata(id), 1'b0};
    q_rr.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v_main    = 4'b0000;
    v_rr      = 4'b0000;
    full_main = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_push"}, 32'(bus.push), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_wr_data"}, bus.wr_data, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: outputs forced low even with every producer valid.
    reset     = 1'b1;
    full_main = 1'b0;
    v_rr      = 4'b0000;
    v_main    = 4'b1111;
    set_data(32'h0000_00A8);
    #2;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: only req 2 valid -> same-cycle push of 0xAA.
    do_reset();
    v_main = 4'b0100;
    #1;
    chk("t1_wr_data_same_cycle", bus.wr_data, 32'h0000_00AA);
    chk("t1_req_ready_same_cycle", 32'(bus.req_ready), 32'h4);
    cyc_main(4'b0100, 1'b0, 1'b1, 2, 1'b0);
    cyc_main(4'b0000, 1'b0, 1'b0, 0, 1'b0);

    // 2: per-beat round-robin, all valid.
    do_reset();
    set_data(32'h2000_0000);
    cyc_rr(4'b1111, 0);
    cyc_rr(4'b1111, 1);
    cyc_rr(4'b1111, 2);
    cyc_rr(4'b1111, 3);
    cyc_rr(4'b1111, 0);
    cyc_rr(4'b1111, 1);
    v_rr = 4'b0000;

    // 3: bursts of 4 between req 0 and 1; locked is the LOCK state, so the first beat of
    // each burst is issued from ARB with locked=0.
    do_reset();
    set_data(32'h3000_0000);
    cyc_main(4'b0011, 1'b0, 1'b1, 0, 1'b0);
    cyc_main(4'b0011, 1'b0, 1'b1, 0, 1'b1);
    cyc_main(4'b0011, 1'b0, 1'b1, 0, 1'b1);
    cyc_main(4'b0011, 1'b0, 1'b1, 0, 1'b1);
    cyc_main(4'b0011, 1'b0, 1'b1, 1, 1'b0);
    cyc_main(4'b0011, 1'b0, 1'b1, 1, 1'b1);
    cyc_main(4'b0011, 1'b0, 1'b1, 1, 1'b1);
    cyc_main(4'b0011, 1'b0, 1'b1, 1, 1'b1);
    cyc_main(4'b0011, 1'b0, 1'b1, 0, 1'b0);
    cyc_main(4'b0000, 1'b0, 1'b0, 0, 1'b0);

    // 4: full for 3 cycles after 2 beats of req 3; burst resumes, then wraps to req 0.
    do_reset();
    set_data(32'h4000_0000);
    cyc_main(4'b1000, 1'b0, 1'b1, 3, 1'b0);
    cyc_main(4'b1001, 1'b0, 1'b1, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      v_main    = 4'b1001;
      full_main = 1'b1;
      #1;
      chk("t4_full_req_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_full_locked_held", 32'(bus.locked), 32'd1);
      cyc_main(4'b1001, 1'b1, 1'b0, 0, 1'b0);
    end
    cyc_main(4'b1001, 1'b0, 1'b1, 3, 1'b1);
    cyc_main(4'b1001, 1'b0, 1'b1, 3, 1'b1);
    cyc_main(4'b1001, 1'b0, 1'b1, 0, 1'b0);
    cyc_main(4'b0000, 1'b0, 1'b0, 0, 1'b0);

    // 5: owner 1 drops after one beat; req 2 granted in that same cycle.
    do_reset();
    set_data(32'h5000_0000);
    cyc_main(4'b0010, 1'b0, 1'b1, 1, 1'b0);
    cyc_main(4'b0100, 1'b0, 1'b1, 2, 1'b1);
    cyc_main(4'b0000, 1'b0, 1'b0, 0, 1'b0);

    // 6: reset mid-LOCK, then rr_ptr restarts at 0.
    do_reset();
    set_data(32'h6000_0000);
    cyc_main(4'b0001, 1'b0, 1'b1, 0, 1'b0);
    cyc_main(4'b0001, 1'b0, 1'b1, 0, 1'b1);
    v_main = 4'b0001;
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("t6_mid_lock_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc_main(4'b1001, 1'b0, 1'b1, 0, 1'b0);
    cyc_main(4'b1000, 1'b0, 1'b1, 3, 1'b1);
    cyc_main(4'b0000, 1'b0, 1'b0, 0, 1'b0);
    cyc_main(4'b0000, 1'b0, 1'b0, 0, 1'b0);

    chk("main_queue_drained", 32'(q_main.size()), 32'd0);
    chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
